// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames into 10-bit RAM command words and serialises read bytes on MISO.
// Optional TX-wait timeout enabled by defining SPI_TX_TIMEOUT_EN.
`timescale 1ns/1ps
module spi_slave_if #(
  parameter int unsigned TX_TIMEOUT = 15,
  parameter int unsigned TO_W       = 4
) (
  input  logic       clk_spi,
  input  logic       rst_n_spi,
  input  logic       SS_n,
  input  logic       MOSI,
  output logic       MISO,
  output logic [9:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t     state, state_nxt;
  logic       rd_addr_received;
  logic [3:0] rx_cnt;
  logic       rx_shift;
  logic       rx_last;
  logic       tx_arm;
  logic       tx_load;
  logic [7:0] tx_shift;
  logic [3:0] tx_cnt;

  if ((64'd1 << TO_W) <= 64'(TX_TIMEOUT)) begin : g_to_w_check
    $error("TO_W is too narrow to count to TX_TIMEOUT");
  end

  always_ff @(posedge clk_spi) begin
    if (!rst_n_spi) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rx_shift  = 1'b0;
    rx_last   = 1'b0;
    if (SS_n) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = CHK_CMD;
        CHK_CMD: begin
          if (!MOSI)                 state_nxt = WRITE;
          else if (rd_addr_received) state_nxt = READ_DATA;
          else                       state_nxt = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          rx_shift = (rx_cnt != 4'd10);
          rx_last  = (rx_cnt == 4'd9);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // tx_arm is raised with rx_valid; the rx_valid cycle itself is excluded so stale tx_valid is never captured.
  always_comb tx_load = tx_arm && !rx_valid && tx_valid;

`ifdef SPI_TX_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_expire;

  always_comb to_expire = tx_arm && !rx_valid && !tx_valid && (to_cnt == TO_W'(TX_TIMEOUT - 1));

  always_ff @(posedge clk_spi) begin
    if (!rst_n_spi || SS_n)                  to_cnt <= '0;
    else if (tx_arm && !rx_valid && !tx_valid) to_cnt <= to_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk_spi) begin
    if (!rst_n_spi) begin
      rx_data          <= '0;
      rx_valid         <= 1'b0;
      rx_cnt           <= '0;
      rd_addr_received <= 1'b0;
      tx_arm           <= 1'b0;
      tx_shift         <= '0;
      tx_cnt           <= '0;
      MISO             <= 1'b0;
    end else if (SS_n) begin
      rx_valid <= 1'b0;
      rx_cnt   <= '0;
      tx_arm   <= 1'b0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      MISO     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (rx_shift) begin
        rx_data <= {rx_data[8:0], MOSI};
        rx_cnt  <= rx_cnt + 4'd1;
      end
      if (rx_last) begin
        rx_valid <= 1'b1;
        if (state == READ_ADD) rd_addr_received <= 1'b1;
        if (state == READ_DATA) begin
          rd_addr_received <= 1'b0;
          tx_arm           <= 1'b1;
        end
      end
      if (tx_load) begin
        tx_shift <= tx_data;
        tx_cnt   <= 4'd8;
        tx_arm   <= 1'b0;
      end
`ifdef SPI_TX_TIMEOUT_EN
      else if (to_expire) begin
        tx_arm <= 1'b0;
      end
`endif
      if (tx_cnt != 4'd0) begin
        MISO     <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
        tx_cnt   <= tx_cnt - 4'd1;
      end else begin
        MISO <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed, table-driven bench for spi_slave_if with a small behavioural RAM on the rx/tx ports.
`timescale 1ns/1ps
module tb_spi_slave_if;

  logic       clk_spi = 1'b0;
  logic       rst_n_spi;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  logic       ram_tv = 1'b0;
  logic [7:0] ram_td = 8'h00;
  logic [7:0] ram_addr = 8'h00;
  logic [7:0] mem [256];
  logic       force_tv = 1'b0;
  logic [7:0] force_td = 8'hC6;

  int n_cmp = 0;
  int n_bad = 0;
  logic miso_log [64];
  int   pulses;
  int   pulse_edge;

  spi_slave_if #(.TX_TIMEOUT(15), .TO_W(4)) dut (
    .clk_spi  (clk_spi),
    .rst_n_spi(rst_n_spi),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  always #5 clk_spi = ~clk_spi;

  assign tx_valid = ram_tv | force_tv;
  assign tx_data  = force_tv ? force_td : ram_td;

  // RAM: opcode 10 latches the read address, opcode 11 returns the byte one cycle later.
  always @(posedge clk_spi) begin
    ram_tv <= 1'b0;
    if (rx_valid) begin
      if (rx_data[9:8] == 2'b10) ram_addr <= rx_data[7:0];
      else if (rx_data[9:8] == 2'b11) begin
        ram_tv <= 1'b1;
        ram_td <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_spi);
    #1;
  endtask

  // Edge e of the frame is the e-th posedge with SS_n low; one SS_n-high edge is logged at index n.
  task automatic frame(input logic typ, input logic [9:0] word, input int n, input int late);
    pulses     = 0;
    pulse_edge = -1;
    for (int e = 0; e < n; e++) begin
      SS_n = 1'b0;
      if (e == 1)                 MOSI = typ;
      else if (e >= 2 && e <= 11) MOSI = word[4'(11 - e)];
      else                        MOSI = 1'($urandom_range(1));
      if (late >= 0) force_tv = (e == late);
      tick();
      miso_log[e] = MISO;
      if (rx_valid) begin
        pulses++;
        if (pulse_edge < 0) pulse_edge = e;
      end
    end
    SS_n     = 1'b1;
    MOSI     = 1'b0;
    force_tv = 1'b0;
    tick();
    miso_log[n] = MISO;
    if (rx_valid) pulses++;
  endtask

  task automatic check_frame(input string name, input int n, input logic [9:0] exp_data,
                             input int exp_pulses, input int bstart, input logic [7:0] exp_byte);
    logic [7:0] got;
    int stray;
    check({name, ".rx_data"}, int'(rx_data), int'(exp_data));
    check({name, ".pulses"}, pulses, exp_pulses);
    if (exp_pulses > 0) check({name, ".pulse_edge"}, pulse_edge, 11);
    if (bstart >= 0) begin
      got = '0;
      for (int i = 0; i < 8; i++) got = {got[6:0], miso_log[bstart + i]};
      check({name, ".miso_byte"}, int'(got), int'(exp_byte));
    end
    stray = 0;
    for (int e = 0; e <= n; e++)
      if (!(bstart >= 0 && e >= bstart && e < bstart + 8) && miso_log[e]) stray++;
    check({name, ".miso_idle"}, stray, 0);
  endtask

  typedef struct {
    logic       typ;
    logic [9:0] word;
    int         n;
    int         late;
    logic [9:0] exp_data;
    int         exp_pulses;
    int         bstart;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vt [16];

  initial begin
    vt[0]  = '{1'b0, 10'h0A5, 14, -1, 10'h0A5, 1, -1, 8'h00};
    vt[1]  = '{1'b0, 10'h3FF, 24, -1, 10'h3FF, 1, -1, 8'h00};
    vt[2]  = '{1'b0, 10'h000, 14, -1, 10'h000, 1, -1, 8'h00};
    vt[3]  = '{1'b0, 10'h155,  7, -1, 10'h00A, 0, -1, 8'h00};
    vt[4]  = '{1'b1, 10'h212, 24, -1, 10'h212, 1, -1, 8'h00};
    vt[5]  = '{1'b1, 10'h300, 24, -1, 10'h300, 1, 14, 8'h5C};
    vt[6]  = '{1'b1, 10'h312, 24, -1, 10'h312, 1, -1, 8'h00};
    vt[7]  = '{1'b1, 10'h300, 24, -1, 10'h300, 1, 14, 8'h5C};
    vt[8]  = '{1'b1, 10'h2AB,  7, -1, 10'h015, 0, -1, 8'h00};
    vt[9]  = '{1'b1, 10'h2AB, 24, -1, 10'h2AB, 1, -1, 8'h00};
    vt[10] = '{1'b1, 10'h3C3, 24, -1, 10'h3C3, 1, 14, 8'hA3};
    vt[11] = '{1'b1, 10'h2AB, 24, -1, 10'h2AB, 1, -1, 8'h00};
    vt[12] = '{1'b1, 10'h2AB, 40, 27, 10'h2AB, 1, 28, 8'hC6};
    vt[13] = '{1'b1, 10'h2AB, 24, -1, 10'h2AB, 1, -1, 8'h00};
`ifdef SPI_TX_TIMEOUT_EN
    vt[14] = '{1'b1, 10'h2AB, 40, 28, 10'h2AB, 1, -1, 8'h00};
`else
    vt[14] = '{1'b1, 10'h2AB, 40, 28, 10'h2AB, 1, 29, 8'hC6};
`endif
    vt[15] = '{1'b0, 10'h1E1, 14, -1, 10'h1E1, 1, -1, 8'h00};

    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h12] = 8'h5C;
    mem[8'hAB] = 8'hA3;

    rst_n_spi = 1'b0;
    SS_n      = 1'b0;
    MOSI      = 1'b0;
    for (int c = 0; c < 6; c++) begin
      MOSI = ~MOSI;
      tick();
      check("reset.MISO", int'(MISO), 0);
      check("reset.rx_valid", int'(rx_valid), 0);
      check("reset.rx_data", int'(rx_data), 0);
    end
    rst_n_spi = 1'b1;
    SS_n      = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      frame(vt[i].typ, vt[i].word, vt[i].n, vt[i].late);
      check_frame($sformatf("vec%0d", i), vt[i].n, vt[i].exp_data, vt[i].exp_pulses,
                  vt[i].bstart, vt[i].exp_byte);
    end

    // tx_valid high before and throughout a read-data frame
    frame(1'b1, 10'h2AB, 14, -1);
    check_frame("stale.addr", 14, 10'h2AB, 1, -1, 8'h00);
    force_tv = 1'b1;
    tick();
    frame(1'b1, 10'h2AB, 24, -1);
    check_frame("stale.data", 24, 10'h2AB, 1, 14, 8'hC6);

    // SS_n rises part-way through the TX byte
    frame(1'b1, 10'h212, 14, -1);
    check_frame("cut.addr", 14, 10'h212, 1, -1, 8'h00);
    frame(1'b1, 10'h300, 17, -1);
    check("cut.pulses", pulses, 1);
    check("cut.bit7", int'(miso_log[14]), 0);
    check("cut.bit6", int'(miso_log[15]), 1);
    check("cut.bit5", int'(miso_log[16]), 0);
    check("cut.after_ss", int'(miso_log[17]), 0);
    frame(1'b1, 10'h312, 24, -1);
    check_frame("cut.next", 24, 10'h312, 1, -1, 8'h00);

    // reset mid read-data frame clears rd_addr_received
    frame(1'b1, 10'h212, 14, -1);
    check_frame("rst.addr", 14, 10'h212, 1, -1, 8'h00);
    for (int e = 0; e < 8; e++) begin
      SS_n = 1'b0;
      if (e == 1)      MOSI = 1'b1;
      else if (e >= 2) MOSI = (e == 2 || e == 3);
      else             MOSI = 1'b0;
      tick();
    end
    rst_n_spi = 1'b0;
    for (int c = 0; c < 2; c++) begin
      MOSI = ~MOSI;
      tick();
      check("rst.mid.rx_valid", int'(rx_valid), 0);
      check("rst.mid.MISO", int'(MISO), 0);
      check("rst.mid.rx_data", int'(rx_data), 0);
    end
    rst_n_spi = 1'b1;
    SS_n      = 1'b1;
    tick();
    check("rst.after.rx_valid", int'(rx_valid), 0);
    frame(1'b1, 10'h312, 24, -1);
    check_frame("rst.next", 24, 10'h312, 1, -1, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
